// File: rtl/led_scan_decoder.sv
// Purpose : rebuild 8x8 RGB frames from a sampled column-scan bus and check red-vs-wall overlap.
// Latency : rd_rgb 1 cycle after address; frame_done 1 cycle after the last sample; overlap_valid 9 cycles after frame_done.
// Backpr. : none -- every scan_valid sample is absorbed; a stalled partial frame is dropped after TIMEOUT idle cycles.
//
// Ports:
//   CLK, Clear            clock, synchronous active-high reset
//   scan_valid, S         sample strobe and column select
//   position_R/G/B        active-low row vectors of the sampled column
//   rd_col, rd_row        read address into the committed frame
//   rd_rgb                {R,G,B} of the addressed pixel, active-high, registered
//   frame_done            one-cycle pulse when a frame is committed
//   frame_count           committed frames, wraps at 256
//   overlap, overlap_valid latched overlap result and its update pulse
//   col_seen              columns sampled at least once in the last committed frame
//   stale                 a partial frame was discarded on timeout
module led_scan_decoder #(
   parameter int FRAME_LEN = 24,
   parameter int TIMEOUT   = 1000000
) (
   input  logic       CLK,
   input  logic       Clear,
   input  logic       scan_valid,
   input  logic [2:0] S,
   input  logic [7:0] position_R,
   input  logic [7:0] position_G,
   input  logic [7:0] position_B,
   input  logic [2:0] rd_col,
   input  logic [2:0] rd_row,
   output logic [2:0] rd_rgb,
   output logic       frame_done,
   output logic [7:0] frame_count,
   output logic       overlap,
   output logic       overlap_valid,
   output logic [7:0] col_seen,
   output logic       stale
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [7:0]        LAST_SAMPLE = 8'(FRAME_LEN - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX    = IDLE_W'(TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_PRE    = IDLE_W'(TIMEOUT - 1);
   localparam logic [IDLE_W-1:0] IDLE_ONE    = 1;

   typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DONE} state_t;

   // Frame planes are [column][row], active-high.
   logic [7:0][7:0]   shd_r_q, shd_g_q, shd_b_q;
   logic [7:0][7:0]   shd_r_d, shd_g_d, shd_b_d;
   logic [7:0]        shd_seen_q, shd_seen_d;
   logic [7:0][7:0]   com_r_q, com_g_q, com_b_q;
   logic [7:0]        cnt_q, cnt_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              commit, discard;
   logic              frame_done_q, stale_q;
   logic [7:0]        frame_count_q, col_seen_q;
   logic [2:0]        rd_rgb_q;

   state_t            state_q, state_d;
   logic [2:0]        col_q, col_d;
   logic              hit_q, hit_d;
   logic              overlap_q;
   logic              col_hit, ld_overlap;

   // ------------------------------------------------------------ accumulation
   always_comb begin
      // The commit sample is folded in through the _d planes so it is not lost.
      commit  = scan_valid && (cnt_q == LAST_SAMPLE);
      // Fires only on the cycle the idle counter reaches TIMEOUT, never again while saturated.
      discard = !scan_valid && (idle_q == IDLE_PRE) && (cnt_q != 8'd0);

      shd_r_d    = shd_r_q;
      shd_g_d    = shd_g_q;
      shd_b_d    = shd_b_q;
      shd_seen_d = shd_seen_q;
      if (scan_valid) begin
         shd_r_d[S]    = shd_r_q[S] | ~position_R;
         shd_g_d[S]    = shd_g_q[S] | ~position_G;
         shd_b_d[S]    = shd_b_q[S] | ~position_B;
         shd_seen_d[S] = 1'b1;
      end

      if (commit || discard)
         cnt_d = 8'd0;
      else if (scan_valid)
         cnt_d = cnt_q + 8'd1;
      else
         cnt_d = cnt_q;

      if (scan_valid)
         idle_d = '0;
      else if (idle_q == IDLE_MAX)
         idle_d = idle_q;
      else
         idle_d = idle_q + IDLE_ONE;
   end

   always_ff @(posedge CLK) begin
      if (Clear) begin
         shd_r_q       <= '0;
         shd_g_q       <= '0;
         shd_b_q       <= '0;
         shd_seen_q    <= '0;
         com_r_q       <= '0;
         com_g_q       <= '0;
         com_b_q       <= '0;
         cnt_q         <= '0;
         idle_q        <= '0;
         frame_done_q  <= 1'b0;
         stale_q       <= 1'b0;
         frame_count_q <= '0;
         col_seen_q    <= '0;
         rd_rgb_q      <= '0;
      end else begin
         cnt_q        <= cnt_d;
         idle_q       <= idle_d;
         frame_done_q <= commit;
         // Read uses the pre-edge buffer; an address held in the frame_done cycle sees the new frame.
         rd_rgb_q     <= {com_r_q[rd_col][rd_row], com_g_q[rd_col][rd_row], com_b_q[rd_col][rd_row]};
         if (commit || discard) begin
            shd_r_q    <= '0;
            shd_g_q    <= '0;
            shd_b_q    <= '0;
            shd_seen_q <= '0;
         end else begin
            shd_r_q    <= shd_r_d;
            shd_g_q    <= shd_g_d;
            shd_b_q    <= shd_b_d;
            shd_seen_q <= shd_seen_d;
         end
         if (commit) begin
            com_r_q       <= shd_r_d;
            com_g_q       <= shd_g_d;
            com_b_q       <= shd_b_d;
            col_seen_q    <= shd_seen_d;
            frame_count_q <= frame_count_q + 8'd1;
            stale_q       <= 1'b0;
         end else if (discard) begin
            stale_q       <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------ overlap check FSM
   assign col_hit = |(com_r_q[col_q] & (com_g_q[col_q] | com_b_q[col_q]));

   always_ff @(posedge CLK) begin
      if (Clear) begin
         state_q   <= ST_IDLE;
         col_q     <= '0;
         hit_q     <= 1'b0;
         overlap_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         hit_q   <= hit_d;
         if (ld_overlap)
            overlap_q <= hit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      hit_d   = hit_q;
      // A fresh commit always restarts the scan, discarding any check in flight.
      if (frame_done_q) begin
         state_d = ST_CHECK;
         col_d   = 3'd0;
         hit_d   = 1'b0;
      end else begin
         case (state_q)
            ST_CHECK: begin
               hit_d = hit_q | col_hit;
               col_d = col_q + 3'd1;
               if (col_q == 3'd7)
                  state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      overlap_valid = 1'b0;
      ld_overlap    = 1'b0;
      if (state_q == ST_DONE)
         overlap_valid = 1'b1;
      // Result is latched on the CHECK->DONE edge so overlap is valid alongside the pulse.
      if ((state_q == ST_CHECK) && (col_q == 3'd7) && !frame_done_q)
         ld_overlap = 1'b1;
   end

   assign rd_rgb      = rd_rgb_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign overlap     = overlap_q;
   assign col_seen    = col_seen_q;
   assign stale       = stale_q;

endmodule

// File: tb/tb_led_scan_decoder.sv
// Purpose : self-checking bench for led_scan_decoder (directed tables, corner sequences, random vs. frame model).
// Latency : one step() per clock; outputs sampled on the falling edge.
// Backpr. : n/a.
module tb_led_scan_decoder;
   localparam int FL = 24;
   localparam int TO = 300;

   logic       CLK = 1'b0;
   logic       Clear, scan_valid;
   logic [2:0] S, rd_col, rd_row, rd_rgb;
   logic [7:0] position_R, position_G, position_B;
   logic       frame_done, overlap, overlap_valid, stale;
   logic [7:0] frame_count, col_seen;

   always #5 CLK = ~CLK;

   led_scan_decoder #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
      .CLK(CLK), .Clear(Clear), .scan_valid(scan_valid), .S(S),
      .position_R(position_R), .position_G(position_G), .position_B(position_B),
      .rd_col(rd_col), .rd_row(rd_row), .rd_rgb(rd_rgb),
      .frame_done(frame_done), .frame_count(frame_count),
      .overlap(overlap), .overlap_valid(overlap_valid),
      .col_seen(col_seen), .stale(stale)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- reference model: a frame is the OR of its sample list
   typedef struct {logic [2:0] s; logic [7:0] r, g, b;} samp_t;
   samp_t      q[$];
   logic [2:0] m_pix [8][8];
   logic [7:0] m_seen;
   int         m_count, m_timer, m_idle;
   logic       m_stale, m_fd, m_ov, m_ovv, m_hitp;
   logic [2:0] m_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int c = 0; c < 8; c++) for (int r = 0; r < 8; r++) m_pix[c][r] = 3'b000;
      m_seen = 8'h00; m_count = 0; m_timer = 0; m_idle = 0;
      m_stale = 0; m_fd = 0; m_ov = 0; m_ovv = 0; m_hitp = 0; m_rd = 3'b000;
   endtask

   task automatic model_commit();
      logic hit;
      for (int c = 0; c < 8; c++) for (int r = 0; r < 8; r++) m_pix[c][r] = 3'b000;
      m_seen = 8'h00;
      foreach (q[i]) begin
         for (int r = 0; r < 8; r++)
            m_pix[q[i].s][r] = m_pix[q[i].s][r] | {~q[i].r[r], ~q[i].g[r], ~q[i].b[r]};
         m_seen[q[i].s] = 1'b1;
      end
      hit = 0;
      for (int c = 0; c < 8; c++)
         for (int r = 0; r < 8; r++)
            if (m_pix[c][r][2] && (m_pix[c][r][1] || m_pix[c][r][0])) hit = 1;
      m_hitp  = hit;
      m_timer = 9;
      m_count = (m_count + 1) % 256;
      m_stale = 0;
      m_fd    = 1;
      q.delete();
   endtask

   task automatic model_edge(input logic v, input logic [2:0] s, input logic [7:0] r, g, b);
      samp_t sm;
      if (Clear) begin
         model_reset();
         return;
      end
      m_rd  = m_pix[rd_col][rd_row];
      m_fd  = 0;
      m_ovv = 0;
      if (m_timer > 0) begin
         m_timer--;
         if (m_timer == 0) begin m_ovv = 1; m_ov = m_hitp; end
      end
      if (!v) begin
         if (m_idle < TO) begin
            m_idle++;
            if (m_idle == TO && q.size() > 0) begin q.delete(); m_stale = 1; end
         end
      end else begin
         m_idle = 0;
         sm.s = s; sm.r = r; sm.g = g; sm.b = b;
         q.push_back(sm);
         if (q.size() == FL) model_commit();
      end
   endtask

   task automatic step(input logic v, input logic [2:0] s, input logic [7:0] r, g, b);
      scan_valid = v; S = s; position_R = r; position_G = g; position_B = b;
      @(posedge CLK);
      model_edge(v, s, r, g, b);
      @(negedge CLK);
      chk("frame_done",    frame_done,    m_fd);
      chk("frame_count",   frame_count,   m_count[7:0]);
      chk("stale",         stale,         m_stale);
      chk("col_seen",      col_seen,      m_seen);
      chk("overlap_valid", overlap_valid, m_ovv);
      chk("overlap",       overlap,       m_ov);
      chk("rd_rgb",        rd_rgb,        m_rd);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF);
   endtask

   task automatic pad(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 3'(i % 8), 8'hFF, 8'hFF, 8'hFF);
   endtask

   function automatic logic [7:0] sparse();
      return ~(8'($urandom) & 8'($urandom) & 8'($urandom));
   endfunction

   // ---------------- directed read vectors
   typedef struct {int tag; logic [2:0] col, row, exp;} rd_vec_t;
   rd_vec_t tab[13];

   task automatic run_tab(input int tag);
      foreach (tab[i]) begin
         if (tab[i].tag == tag) begin
            rd_col = tab[i].col; rd_row = tab[i].row;
            idle(1);
            chk($sformatf("rd_tab%0d_%0d_%0d", tag, tab[i].col, tab[i].row), rd_rgb, tab[i].exp);
         end
      end
   endtask

   task automatic ov_latency(input logic exp_ov);
      int lat;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         idle(1);
         if (overlap_valid === 1'b1) begin lat = k; break; end
      end
      chk("ov_latency", lat, 9);
      chk("ov_value", overlap, exp_ov);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int npulse;
      tab[0]  = '{1, 3'd0, 3'd0, 3'b100};
      tab[1]  = '{1, 3'd1, 3'd0, 3'b000};
      tab[2]  = '{1, 3'd0, 3'd1, 3'b000};
      tab[3]  = '{1, 3'd7, 3'd7, 3'b000};
      tab[4]  = '{2, 3'd3, 3'd3, 3'b101};
      tab[5]  = '{2, 3'd3, 3'd4, 3'b000};
      tab[6]  = '{2, 3'd2, 3'd3, 3'b000};
      tab[7]  = '{3, 3'd3, 3'd3, 3'b100};
      tab[8]  = '{3, 3'd3, 3'd4, 3'b001};
      tab[9]  = '{3, 3'd4, 3'd3, 3'b000};
      tab[10] = '{4, 3'd2, 3'd2, 3'b000};
      tab[11] = '{4, 3'd2, 3'd5, 3'b001};
      tab[12] = '{4, 3'd7, 3'd5, 3'b001};

      model_reset();
      Clear = 1; scan_valid = 0; S = 0; rd_col = 0; rd_row = 0;
      position_R = 8'hFF; position_G = 8'hFF; position_B = 8'hFF;
      idle(2);
      Clear = 0;
      idle(1);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_col_seen", col_seen, 0);
      chk("rst_rd_rgb", rd_rgb, 0);

      // frame 1: red at (0,0)
      npulse = 0;
      for (int i = 0; i < FL; i++) begin
         step(1'b1, 3'(i % 8), (i % 8 == 0) ? 8'hFE : 8'hFF, 8'hFF, 8'hFF);
         if (frame_done === 1'b1) npulse++;
      end
      chk("f1_pulses", npulse, 1);
      chk("f1_count", frame_count, 1);
      chk("f1_col_seen", col_seen, 8'hFF);
      run_tab(1);

      // frame 2: red and blue coincide at (3,3)
      step(1'b1, 3'd3, 8'hF7, 8'hFF, 8'hFF);
      step(1'b1, 3'd3, 8'hFF, 8'hFF, 8'hF7);
      pad(FL - 2);
      chk("f2_done", frame_done, 1);
      ov_latency(1'b1);
      run_tab(2);

      // frame 3: red at (3,3), blue at (3,4)
      step(1'b1, 3'd3, 8'hF7, 8'hFF, 8'hFF);
      step(1'b1, 3'd3, 8'hFF, 8'hFF, 8'hEF);
      pad(FL - 2);
      chk("f3_done", frame_done, 1);
      ov_latency(1'b0);
      run_tab(3);

      // timeout discard of a partial frame
      for (int i = 0; i < 10; i++) step(1'b1, 3'(i % 8), 8'hFF, 8'hFB, 8'hFF);
      idle(TO - 1);
      chk("stale_before_limit", stale, 0);
      idle(1);
      chk("stale_at_limit", stale, 1);
      chk("stale_count_kept", frame_count, 3);
      idle(50);
      for (int i = 0; i < FL; i++) step(1'b1, 3'(i % 8), 8'hFF, 8'hFF, 8'hDF);
      chk("to_done", frame_done, 1);
      chk("to_stale_clr", stale, 0);
      run_tab(4);

      // back-to-back samples across the commit boundary
      rd_col = 3'd5; rd_row = 3'd7;
      pad(FL);
      chk("b2b_done1", frame_done, 1);
      step(1'b1, 3'd5, 8'hFF, 8'h7F, 8'hFF);
      chk("b2b_frame1_px", rd_rgb, 3'b000);
      pad(FL - 1);
      chk("b2b_done2", frame_done, 1);
      idle(1);
      chk("b2b_frame2_px", rd_rgb, 3'b010);
      chk("b2b_count", frame_count, 6);

      // Clear while the overlap check is running
      step(1'b1, 3'd1, 8'hFD, 8'hFD, 8'hFF);
      pad(FL - 1);
      idle(12);
      chk("pre_clr_overlap", overlap, 1);
      step(1'b1, 3'd1, 8'hFD, 8'hFD, 8'hFF);
      pad(FL - 1);
      idle(3);
      Clear = 1;
      idle(1);
      Clear = 0;
      chk("clr_frame_done", frame_done, 0);
      chk("clr_count", frame_count, 0);
      chk("clr_overlap", overlap, 0);
      chk("clr_col_seen", col_seen, 0);
      chk("clr_stale", stale, 0);
      chk("clr_rd", rd_rgb, 0);
      npulse = 0;
      repeat (15) begin
         idle(1);
         if (overlap_valid === 1'b1) npulse++;
      end
      chk("clr_no_pulse", npulse, 0);

      // randomized traffic against the frame model
      for (int n = 0; n < 4000; n++) begin
         rd_col = 3'($urandom_range(0, 7));
         rd_row = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 999) == 0) begin
            Clear = 1; idle(1); Clear = 0;
         end else if ($urandom_range(0, 599) == 0) begin
            idle(TO + int'($urandom_range(0, 20)));
         end else if ($urandom_range(0, 3) != 0) begin
            step(1'b1, 3'($urandom_range(0, 7)), sparse(), sparse(), sparse());
         end else begin
            idle(1);
         end
      end

      // frame_count wrap
      Clear = 1; idle(1); Clear = 0;
      repeat (255) pad(FL);
      chk("wrap_255", frame_count, 255);
      pad(FL);
      chk("wrap_0", frame_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/led_scan_decoder.md
Name: led_scan_decoder

Overview:
- Receive-side counterpart of the 8x8 RGB matrix scan driver.
- Samples the time-multiplexed column-select/row bus (S, active-low position_R/G/B) and rebuilds full frames in an internal frame buffer.
- Exposes a 1-cycle-latency pixel read port, a per-frame overlap check (player red vs. blue/green walls), and frame statistics.
- Used on-chip for collision cross-checking, and in benches as the display monitor.

Parameters:
FRAME_LEN, 24, number of valid scan samples that make up one frame (1..255)
TIMEOUT, 1000000, idle CLK cycles without scan_valid before a partial frame is discarded

Ports:
CLK  input  1  system clock
Clear  input  1  synchronous active-high reset
scan_valid  input  1  one-cycle strobe: S/position_* hold a valid sample this cycle
S  input  3  column select of the sample
position_R  input  8  red row vector, active-low (0 = lit)
position_G  input  8  green row vector, active-low
position_B  input  8  blue row vector, active-low
rd_col  input  3  read column address
rd_row  input  3  read row address
rd_rgb  output  3  {R,G,B} of committed pixel, active-high
frame_done  output  1  one-cycle pulse when a frame is committed
frame_count  output  8  committed frames, wraps 255->0
overlap  output  1  latched result of last check: red pixel coincides with blue or green
overlap_valid  output  1  one-cycle pulse when overlap is updated
col_seen  output  8  columns written at least once in the last committed frame
stale  output  1  set on timeout discard, cleared by next frame_done

Behaviour:
- Clear is synchronous and active-high; it is the only reset. Everything below is sampled on the CLK rising edge.
- Reset values:
  - rd_rgb=0, frame_done=0, frame_count=0, overlap=0, overlap_valid=0, col_seen=0, stale=0.
  - Shadow and committed buffers all-zero.
  - Sample counter=0, idle counter=0, check FSM in IDLE.
- Accumulation:
  - On scan_valid, the shadow column S is updated as shadow[S] |= ~position_R/G/B, per colour plane.
  - Repeated samples of the same column within one frame therefore OR together.
  - shadow_seen[S] is set.
- Frame commit:
  - Occurs on the scan_valid cycle that brings the sample counter to FRAME_LEN, and includes that sample.
  - Next cycle: committed buffer = shadow (including the last sample), col_seen = shadow_seen, frame_done=1 for one cycle, frame_count+1.
  - On that same cycle the shadow, shadow_seen and sample counter clear, and stale clears.
  - A scan_valid arriving the cycle after the commit sample lands in the fresh shadow, so no sample is lost.
- Check FSM, states IDLE -> CHECK -> DONE -> IDLE:
  - frame_done moves IDLE to CHECK, and a column index starts at 0.
  - CHECK takes 8 cycles, one column per cycle. It accumulates hit |= |(R[c] & (G[c] | B[c])) over the committed buffer.
  - DONE takes one cycle: overlap=hit, overlap_valid=1, then back to IDLE.
  - frame_done to overlap_valid is 9 cycles.
  - A commit while in CHECK or DONE is legal only if the FSM returns to IDLE first. FRAME_LEN>=10 guarantees this. If it happens anyway, the check restarts at column 0 on the new buffer and the old result is dropped, with no overlap_valid pulse for it.
  - The committed buffer is never written during CHECK except by a new commit.
- Timeout:
  - The idle counter increments every cycle without scan_valid and resets on scan_valid.
  - On reaching TIMEOUT with the sample counter non-zero: the shadow, shadow_seen and sample counter clear, and stale=1.
  - The committed buffer, frame_count and overlap are unchanged.
  - The idle counter saturates at TIMEOUT, so no repeated action.
- Read port: rd_rgb is registered from the committed buffer at (rd_col, rd_row), so data appears 1 cycle after the address. On the frame_done cycle the read returns new-frame data.
- Arithmetic: the sample counter is 8 bits, and FRAME_LEN=0 is illegal. frame_count wraps modulo 256.
- Clear mid-frame or mid-check aborts everything to reset values within the same edge.

Test Plan:
- Reset, then 24 samples with S=0..7 repeating, position_R=8'b11111110 only on S=0 and all other vectors 8'hFF -> frame_done pulse once, frame_count=1, col_seen=8'hFF, rd (0,0) -> rgb=3'b100, rd (1,0) -> 3'b000.
- Two samples on S=3: R=8'b11110111, then B=8'b11110111; pad to 24 -> rd (3,3)=3'b101; 9 cycles after frame_done, overlap_valid=1 with overlap=1.
- Same frame with R only at (3,3) and B at (3,4) -> overlap_valid pulse, overlap=0.
- 10 samples, then 1000000 idle cycles -> stale=1, frame_count unchanged; 24 more samples -> frame_done, stale=0, and the buffer holds only the new samples.
- Back-to-back scan_valid across the commit boundary: sample 25 carries G at (5,7) -> appears in frame 2, not frame 1.
- Assert Clear during the CHECK state -> no overlap_valid pulse, all outputs zero on the next cycle; 256 frames -> frame_count wraps to 0.
